// File: rtl/led_scan_display_pkg.sv
// -----------------------------------------------------------------------------
// led_scan_display_pkg
// Shared definitions for the LED scan display:
//   - disp_sel encodings selecting which 32-bit value is shown
//   - active-low 7-segment patterns {dp,g,f,e,d,c,b,a} for blank and dash
//   - hex_to_seg: 4-bit nibble -> active-low {g,f,e,d,c,b,a} pattern
// -----------------------------------------------------------------------------
package led_scan_display_pkg;

   typedef enum logic [1:0] {
      DSEL_LED    = 2'd0,
      DSEL_TOTAL  = 2'd1,
      DSEL_UNCOND = 2'd2,
      DSEL_COND   = 2'd3
   } disp_sel_e;

   localparam logic [7:0] SEG_DASH = 8'hBF;
   localparam logic [7:0] SEG_OFF  = 8'hFF;

   // Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      seg = 7'h7F;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Combinational hex digit decoder for a common-anode 7-segment digit.
// Ports:
//   nibble  in  4  hex value 0-F
//   seg     out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decoder
   import led_scan_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/led_scan_display.sv
// -----------------------------------------------------------------------------
// led_scan_display
// Captures the CPU's syscall-34 LED value and drives a time-multiplexed 8-digit
// 7-segment display. The shown value is either the captured data or one of the
// CPU performance counters, chosen by disp_sel and latched once per frame so a
// frame never mixes two values.
// Ports:
//   clk                 in   1   system clock, rising edge
//   rst                 in   1   synchronous active-low reset
//   led_cpu_enable      in   1   capture strobe (one cycle per syscall-34)
//   led_data_in         in   32  value captured on the strobe
//   total_cycles        in   32  CPU cycle counter
//   uncondi_branch_num  in   32  CPU unconditional-branch counter
//   condi_branch_num    in   32  CPU conditional-branch counter
//   disp_sel            in   2   0=LED data, 1=total, 2=uncondi, 3=condi
//   seg_an              out  8   digit enables, active-low, bit0 = rightmost
//   seg_cat             out  8   segments {dp,g,f,e,d,c,b,a}, active-low
//   led_valid           out  1   at least one capture since reset
// -----------------------------------------------------------------------------
module led_scan_display
   import led_scan_display_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int DIGITS   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_cpu_enable,
   input  logic [31:0] led_data_in,
   input  logic [31:0] total_cycles,
   input  logic [31:0] uncondi_branch_num,
   input  logic [31:0] condi_branch_num,
   input  logic [1:0]  disp_sel,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat,
   output logic        led_valid
);

   localparam int                 PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [2:0]         IDX_LAST   = 3'(DIGITS - 1);

   logic [31:0]        cap_reg;
   logic [31:0]        shadow;
   logic [31:0]        src_value;
   logic [PRESC_W-1:0] presc;
   logic [2:0]         idx;
   logic               load_pending;
   disp_sel_e          mode_sel;
   logic               mode_blank;
   logic               digit_tick;
   logic               frame_wrap;
   logic [3:0]         nibble;
   logic [6:0]         hex_seg;
   logic               dp_n;

   // Capture register: the last strobe wins when strobes are back to back.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cap_reg   <= 32'h0;
         led_valid <= 1'b0;
      end else if (led_cpu_enable) begin
         cap_reg   <= led_data_in;
         led_valid <= 1'b1;
      end
   end

   assign digit_tick = (presc == PRESC_LAST);
   assign frame_wrap = digit_tick && (idx == IDX_LAST);

   // Scan timing: each digit is lit for SCAN_DIV clocks.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc <= '0;
         idx   <= 3'd0;
      end else if (digit_tick) begin
         presc <= '0;
         idx   <= idx + 3'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Source selection, evaluated on pre-edge values.
   always_comb begin
      src_value = cap_reg;
      case (disp_sel_e'(disp_sel))
         DSEL_LED:    src_value = cap_reg;
         DSEL_TOTAL:  src_value = total_cycles;
         DSEL_UNCOND: src_value = uncondi_branch_num;
         DSEL_COND:   src_value = condi_branch_num;
         default:     src_value = cap_reg;
      endcase
   end

   // Frame shadow: value and display mode only change on a frame boundary, or
   // on the first edge after reset so the first frame reflects current inputs.
   // Reset mode is blank so the very first digit after release shows a dash.
   always_ff @(posedge clk) begin
      if (!rst) begin
         shadow       <= 32'h0;
         mode_sel     <= DSEL_LED;
         mode_blank   <= 1'b1;
         load_pending <= 1'b1;
      end else begin
         load_pending <= 1'b0;
         if (frame_wrap || load_pending) begin
            shadow     <= src_value;
            mode_sel   <= disp_sel_e'(disp_sel);
            mode_blank <= (disp_sel == DSEL_LED) && !led_valid;
         end
      end
   end

   assign nibble = shadow[{idx, 2'b00} +: 4];

   seg7_hex_decoder u_decoder (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   // Decimal point marks the leftmost digit when a counter is displayed.
   assign dp_n = !((mode_sel != DSEL_LED) && (idx == IDX_LAST));

   // Registered outputs, one cycle behind (idx, shadow).
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_an  <= SEG_OFF;
         seg_cat <= SEG_OFF;
      end else begin
         seg_an <= ~(8'b0000_0001 << idx);
         if (mode_blank) begin
            seg_cat <= SEG_DASH;
         end else begin
            seg_cat <= {dp_n, hex_seg};
         end
      end
   end

endmodule
